// File: rtl/mac_feeder.sv
// Operand feeder for the vector MAC unit: gathers n signed data/weight pairs into packed lanes,
// holds them on the mac interface until it answers, then offers the result. Optional watchdog: MAC_FEEDER_TIMEOUT_EN.
module mac_feeder #(
    parameter int MAX_MACS       = 64,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [10:0]                    cmd_num_macs,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic [DATA_WIDTH-1:0]          in_weight,
    output logic [10:0]                    mac_num_macs,
    output logic                           mac_valid,
    output logic [MAX_MACS*DATA_WIDTH-1:0] mac_data,
    output logic [MAX_MACS*DATA_WIDTH-1:0] mac_weight,
    input  logic [2*DATA_WIDTH-1:0]        mac_result,
    input  logic                           mac_done,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [2*DATA_WIDTH-1:0]        res_data,
    output logic                           res_err
);

    localparam int          VEC_W = MAX_MACS * DATA_WIDTH;
    localparam logic [10:0] MAX_N = 11'(MAX_MACS);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, RESULT} state_t;

    state_t                  state, state_nxt;
    logic [10:0]             n_q;
    logic [10:0]             idx_q;
    logic [VEC_W-1:0]        data_q;
    logic [VEC_W-1:0]        weight_q;
    logic [2*DATA_WIDTH-1:0] res_q;
    logic [10:0]             n_cmd;
    logic                    last_beat;
    logic                    expire;

    assign n_cmd     = (cmd_num_macs > MAX_N) ? MAX_N : cmd_num_macs;
    assign last_beat = in_valid && (idx_q == n_q - 11'd1);

`ifdef MAC_FEEDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign expire = (state == ISSUE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter idles at 0 outside ISSUE, so it restarts from 0 on every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state == ISSUE) ? cnt_q + CNT_W'(1) : '0;
            if (state == IDLE && cmd_valid)
                err_q <= 1'b0;
            else if (expire && !mac_done)
                err_q <= 1'b1;
        end
    end

    assign res_err = err_q;
`else
    assign expire  = 1'b0;
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = (n_cmd == 11'd0) ? RESULT : LOAD;
            LOAD:    if (last_beat) state_nxt = ISSUE;
            ISSUE:   if (mac_done || expire) state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the lane vectors are reset even though they are datapath, because they drive mac
    // directly and must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q      <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            weight_q <= '0;
            res_q    <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    n_q      <= n_cmd;
                    idx_q    <= '0;
                    data_q   <= '0;
                    weight_q <= '0;
                    res_q    <= '0;
                end
                LOAD: if (in_valid) begin
                    for (int i = 0; i < MAX_MACS; i++) begin
                        if (idx_q == 11'(i)) begin
                            data_q[i*DATA_WIDTH +: DATA_WIDTH]   <= in_data;
                            weight_q[i*DATA_WIDTH +: DATA_WIDTH] <= in_weight;
                        end
                    end
                    idx_q <= idx_q + 11'd1;
                end
                // On a watchdog expiry res_q keeps the 0 written at command accept.
                ISSUE: if (mac_done) res_q <= mac_result;
                default: ;
            endcase
        end
    end

    assign cmd_ready    = (state == IDLE);
    assign in_ready     = (state == LOAD);
    assign mac_valid    = (state == ISSUE);
    assign res_valid    = (state == RESULT);
    assign mac_num_macs = n_q;
    assign mac_data     = data_q;
    assign mac_weight   = weight_q;
    assign res_data     = res_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder with a behavioral mac model and a result scoreboard.
module tb_mac_feeder;

    localparam int LANES = 64;
    localparam int DW    = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic [10:0]           cmd_num_macs = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DW-1:0]         in_data = '0;
    logic [DW-1:0]         in_weight = '0;
    logic [10:0]           mac_num_macs;
    logic                  mac_valid;
    logic [LANES*DW-1:0]   mac_data;
    logic [LANES*DW-1:0]   mac_weight;
    logic [2*DW-1:0]       mac_result;
    logic                  mac_done;
    logic                  res_valid;
    logic                  res_ready = 1'b0;
    logic [2*DW-1:0]       res_data;
    logic                  res_err;

    typedef struct {
        logic [2*DW-1:0] data;
        logic            err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   beats = 0;

    mac_feeder #(.MAX_MACS(LANES), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_macs(cmd_num_macs),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
        .mac_num_macs(mac_num_macs), .mac_valid(mac_valid), .mac_data(mac_data),
        .mac_weight(mac_weight), .mac_result(mac_result), .mac_done(mac_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
    );

    always #5 clk = ~clk;

    // Behavioral mac: valid_out seen by the feeder on the 3rd edge after valid_in rises.
    logic            model_on = 1'b1;
    logic            model_done = 1'b0;
    logic            extra_done = 1'b0;
    int              mcnt = 0;
    logic [2*DW-1:0] model_res = '0;

    function automatic logic [2*DW-1:0] model_dot(input logic [LANES*DW-1:0] d, input logic [LANES*DW-1:0] w);
        int acc = 0;
        for (int i = 0; i < LANES; i++)
            acc += int'($signed(d[i*DW +: DW])) * int'($signed(w[i*DW +: DW]));
        return 16'(acc);
    endfunction

    always @(posedge clk) begin
        if (rst || !mac_valid || !model_on) begin
            model_done <= 1'b0;
            mcnt       <= 0;
        end else begin
            mcnt <= mcnt + 1;
            if (mcnt == 1) begin
                model_done <= 1'b1;
                model_res  <= model_dot(mac_data, mac_weight);
            end
        end
    end

    assign mac_done   = model_done | extra_done;
    assign mac_result = model_res;

    always @(posedge clk) if (in_valid && in_ready) beats++;

    function automatic logic [2*DW-1:0] exp_dot(input int n);
        int acc = 0;
        for (int i = 0; i < n; i++) acc += (i - 99) * (64 - i);
        return 16'(acc);
    endfunction

    task automatic send_cmd(input logic [10:0] n);
        bit acc = 1'b0;
        int t = 0;
        cmd_valid    = 1'b1;
        cmd_num_macs = n;
        while (!acc && t < 200) begin
            acc = cmd_ready;
            @(posedge clk); #1;
            t++;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL cmd_accept timeout: cmd_ready got 0 want 1");
        end
    endtask

    task automatic feed(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            bit acc = 1'b0;
            int t = 0;
            if (gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid  = 1'b1;
            in_data   = 8'(i - 99);
            in_weight = 8'(64 - i);
            while (!acc && t < 200) begin
                acc = in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) begin
                n_cmp++; n_bad++;
                $display("FAIL in_accept timeout lane %0d: in_ready got 0 want 1", i);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int hold, input string name);
        int              t = 0;
        bit              ok = 1'b1;
        exp_t            e;
        logic [2*DW-1:0] d0;
        logic            e0;
        while (!res_valid && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        if (!res_valid) begin
            n_bad++;
            $display("FAIL %s res_valid timeout: got 0 want 1", name);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        d0 = res_data;
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                if (res_valid !== 1'b1 || res_data !== d0 || cmd_ready !== 1'b0) ok = 1'b0;
            end
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s hold_stable: res_valid=%b res_data=%0d cmd_ready=%b want 1/%0d/0",
                         name, res_valid, $signed(res_data), cmd_ready, $signed(d0));
            end
        end
        d0        = res_data;
        e0        = res_err;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s scoreboard empty: got res_data=%0d", name, $signed(d0));
        end else begin
            e = sb.pop_front();
            if (d0 !== e.data || e0 !== e.err) begin
                n_bad++;
                $display("FAIL %s result: got data=%0d err=%b want data=%0d err=%b",
                         name, $signed(d0), e0, $signed(e.data), e.err);
            end
        end
        n_cmp++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s post_handshake: cmd_ready=%b res_valid=%b want 1/0", name, cmd_ready, res_valid);
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || mac_valid !== 1'b0 || res_valid !== 1'b0 || res_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: cmd/in/mac/res/err got %b%b%b%b%b want 10000",
                     cmd_ready, in_ready, mac_valid, res_valid, res_err);
        end
        n_cmp++;
        if (mac_num_macs !== 11'd0 || mac_data !== '0 || mac_weight !== '0 || res_data !== '0) begin
            n_bad++;
            $display("FAIL reset_data: num=%0d data_or=%b weight_or=%b res=%0d want all 0",
                     mac_num_macs, |mac_data, |mac_weight, res_data);
        end
    endtask

    task automatic test_single;
        logic [LANES*DW-1:0] ed = '0;
        logic [LANES*DW-1:0] ew = '0;
        ed[7:0] = 8'h9D;
        ew[7:0] = 8'd64;
        sb.push_back('{data: 16'(-6336), err: 1'b0});
        send_cmd(11'd1);
        feed(1, 1'b0);
        n_cmp++;
        if (mac_valid !== 1'b1 || mac_data !== ed || mac_weight !== ew) begin
            n_bad++;
            $display("FAIL single_lanes: mac_valid=%b lane0 d=%0d w=%0d upper_or=%b want 1/-99/64/0",
                     mac_valid, $signed(mac_data[7:0]), $signed(mac_weight[7:0]),
                     |{mac_data[LANES*DW-1:8], mac_weight[LANES*DW-1:8]});
        end
        wait_result(0, "single");
    endtask

    task automatic test_two;
        int hi = 0;
        sb.push_back('{data: exp_dot(2), err: 1'b0});
        send_cmd(11'd2);
        feed(2, 1'b0);
        n_cmp++;
        if (mac_num_macs !== 11'd2) begin
            n_bad++;
            $display("FAIL two_num_macs: got %0d want 2", mac_num_macs);
        end
        while (mac_valid && hi < 50) begin
            hi++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (hi != 3 || res_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL two_valid_window: mac_valid cycles=%0d res_valid=%b want 3/1", hi, res_valid);
        end
        wait_result(0, "two");
    endtask

    task automatic test_zero;
        int b0 = beats;
        sb.push_back('{data: 16'd0, err: 1'b0});
        send_cmd(11'd0);
        n_cmp++;
        if (res_valid !== 1'b1 || res_data !== 16'd0 || mac_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_immediate: res_valid=%b res_data=%0d mac_valid=%b in_ready=%b want 1/0/0/0",
                     res_valid, $signed(res_data), mac_valid, in_ready);
        end
        wait_result(0, "zero");
        n_cmp++;
        if (beats != b0) begin
            n_bad++;
            $display("FAIL zero_beats: got %0d want 0", beats - b0);
        end
    endtask

    task automatic test_clamp;
        int b0 = beats;
        sb.push_back('{data: exp_dot(64), err: 1'b0});
        send_cmd(11'd100);
        n_cmp++;
        if (mac_num_macs !== 11'd64) begin
            n_bad++;
            $display("FAIL clamp_num_macs: got %0d want 64", mac_num_macs);
        end
        feed(64, 1'b0);
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (beats - b0 != 64) begin
            n_bad++;
            $display("FAIL clamp_beats: got %0d want 64", beats - b0);
        end
        wait_result(0, "clamp");
    endtask

    task automatic test_backpressure;
        logic [LANES*DW-1:0] ed = '0;
        logic [LANES*DW-1:0] ew = '0;
        for (int i = 0; i < 3; i++) begin
            ed[i*DW +: DW] = 8'(i - 99);
            ew[i*DW +: DW] = 8'(64 - i);
        end
        sb.push_back('{data: exp_dot(3), err: 1'b0});
        send_cmd(11'd3);
        feed(3, 1'b1);
        n_cmp++;
        if (mac_data !== ed || mac_weight !== ew || mac_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_lanes: lanes0-2 d=%h w=%h mac_valid=%b want d=%h w=%h 1",
                     mac_data[23:0], mac_weight[23:0], mac_valid, ed[23:0], ew[23:0]);
        end
        wait_result(5, "backpressure");
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        model_on = 1'b0;
        send_cmd(11'd2);
        feed(2, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (mac_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid: mac_valid=%b cmd_ready=%b want 0/1", mac_valid, cmd_ready);
        end
        extra_done = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) extra_done = 1'b0;
            @(posedge clk); #1;
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL late_done: res_valid got 1 want 0");
        end
        model_on = 1'b1;
    endtask

`ifdef MAC_FEEDER_TIMEOUT_EN
    task automatic test_timeout;
        int t = 0;
        model_on = 1'b0;
        sb.push_back('{data: 16'd0, err: 1'b1});
        send_cmd(11'd1);
        feed(1, 1'b0);
        while (!res_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        if (t != 16 || mac_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles mac_valid=%b want 16/0", t, mac_valid);
        end
        wait_result(0, "timeout");
        model_on = 1'b1;
    endtask
`endif

    initial begin
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_single();
        test_two();
        test_zero();
        test_clamp();
        test_backpressure();
        test_reset_mid();
`ifdef MAC_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mac_feeder.md
# mac_feeder

Initiator-side driver for the `mac` vector multiply-accumulate unit. It accepts a MAC command (element count), collects that many signed data/weight byte pairs from an element stream, and packs them into the flat `data`/`weight` vectors `mac` consumes. It then holds `valid_in` until `mac` returns `valid_out`, captures `mac_out`, and presents it on a result handshake. It sits between the operand buffers and `mac` in the NPU datapath.

## Interface
Parameters:
- `MAX_MACS`, 64, number of lanes in the packed vectors.
- `DATA_WIDTH`, 8, signed element width.
- `TIMEOUT_CYCLES`, 1024, watchdog limit in ISSUE; used only with `MAC_FEEDER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both high.
- `cmd_num_macs`  in  11  element count for the operation.
- `in_valid`  in  1  element pair offered.
- `in_ready`  out  1  element pair accepted when both high.
- `in_data`  in  DATA_WIDTH  signed data element.
- `in_weight`  in  DATA_WIDTH  signed weight element.
- `mac_num_macs`  out  11  to `mac.num_macs_i`.
- `mac_valid`  out  1  to `mac.valid_in`.
- `mac_data`  out  MAX_MACS*DATA_WIDTH  to `mac.data`; lane i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `mac_weight`  out  MAX_MACS*DATA_WIDTH  to `mac.weight`; same lane packing.
- `mac_result`  in  2*DATA_WIDTH  from `mac.mac_out`, signed.
- `mac_done`  in  1  from `mac.valid_out`.
- `res_valid`  out  1  result offered.
- `res_ready`  in  1  result consumed when both high.
- `res_data`  out  2*DATA_WIDTH  signed MAC result.
- `res_err`  out  1  qualifies `res_data`: watchdog expired. Constant 0 when the watchdog is compiled out.

## Operation
- States: IDLE, LOAD, ISSUE, RESULT.
- IDLE:
  - `cmd_ready`=1.
  - On a command handshake, latch n = min(`cmd_num_macs`, MAX_MACS), clear both vectors to 0, and clear the lane index.
  - n≠0 → LOAD.
  - n=0 → RESULT with `res_data`=0 and `res_err`=0; `mac_valid` never rises.
- LOAD:
  - `in_ready`=1.
  - Each handshake writes lane[index] of both vectors and increments the index.
  - The handshake on lane n−1 → ISSUE.
- ISSUE:
  - `mac_valid`=1 continuously.
  - `mac_num_macs`=n, and both vectors are held stable.
  - The first cycle with `mac_done`=1 captures `mac_result` into `res_data` and moves to RESULT.
- RESULT:
  - `res_valid`=1, with `res_data`/`res_err` stable until `res_ready`.
  - The handshake → IDLE.
- Lanes ≥ n are always 0, so the packed dot product is correct even if `mac` ignores `num_macs_i`.
- `mac_done` is ignored outside ISSUE.
- Stream beats beyond n are not accepted, because `in_ready`=0 outside LOAD.
- `cmd_ready`=0 outside IDLE; a new command is accepted only in IDLE, never in the same cycle as a result handshake.
- `cmd_num_macs` > MAX_MACS is clamped, and `mac_num_macs` reports the clamped value.

## Timing
- Reset values (the state after the first rising edge with `rst`=1):
  - State is IDLE.
  - `cmd_ready`=1.
  - `in_ready`, `mac_valid`, `res_valid` and `res_err` are 0.
  - `mac_num_macs`, `mac_data`, `mac_weight` and `res_data` are 0.
- Reset mid-operation aborts immediately; `mac_valid` is 0 on the next cycle.
- All outputs are registered or decoded from registered state. There are no combinational input→output paths except `cmd_ready`/`in_ready`, which depend only on state.
- Last element accepted at edge k → `mac_valid`=1 from edge k.
- `mac_done` sampled at edge m → `res_valid`=1 and `mac_valid`=0 from edge m.
  - This guarantees at least one cycle of `mac_valid` low between operations.
- Result handshake at edge r → `cmd_ready`=1 from edge r.
- Minimum command-to-command spacing is n + MAC latency + 2 cycles.

## Configuration
- `MAC_FEEDER_TIMEOUT_EN` defined:
  - An ISSUE cycle counter starts at 0 on entry.
  - If it reaches TIMEOUT_CYCLES without `mac_done`, the block goes to RESULT with `res_data`=0 and `res_err`=1. `mac_valid` drops on that edge.
  - `mac_done` arriving in the same cycle as expiry wins: the result is captured and `res_err`=0.
- `MAC_FEEDER_TIMEOUT_EN` not defined:
  - No counter; ISSUE waits indefinitely.
  - `res_err` is tied to 0.

## Test plan
- Bench setup: behavioral `mac` model that asserts `valid_out` 3 cycles after `valid_in` rises; elements data[i]=i+1−100, weight[i]=64−i.
- n=1 → `mac_data` lane0=−99, lane0 weight=64, all other lanes 0; `res_data`=−6336 and `res_err`=0.
- n=2 → `res_data`=−12510; `mac_valid` stays high exactly until the cycle `mac_done` is sampled, and `mac_num_macs`=2.
- `cmd_num_macs`=0 → `res_valid` on the next cycle with `res_data`=0; `mac_valid` stays 0 and `in_ready` never rises. `cmd_num_macs`=100 → `mac_num_macs`=64 and exactly 64 beats are accepted.
- Backpressure: `res_ready` held low for 5 cycles after `res_valid` → `res_valid`/`res_data` stable and `cmd_ready`=0 throughout; the handshake returns to IDLE. With `in_valid` toggling every other cycle during LOAD, all n lanes load correctly.
- `rst` asserted for 1 cycle while in ISSUE → `mac_valid`=0 and `cmd_ready`=1 next cycle. A late `mac_done` produces no `res_valid`.
- With `MAC_FEEDER_TIMEOUT_EN` and TIMEOUT_CYCLES=16, the model never responds → `res_valid`=1 with `res_err`=1 and `res_data`=0 exactly 16 cycles after ISSUE entry.
